// File: rtl/sbox_lane_engine.sv
// Column-wise S-box substitution engine: captures NCOLS columns, looks up LANES columns per
// cycle through a writable table, and holds the result until the consumer accepts it.
module sbox_lane_engine #(
  parameter int unsigned COL_W = 5,
  parameter int unsigned LANES = 4,
  parameter int unsigned NCOLS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [COL_W-1:0]       cfg_addr,
  input  logic [COL_W-1:0]       cfg_data,
  output logic                   cfg_ready,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCOLS*COL_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCOLS*COL_W-1:0] out_data
);

  localparam int unsigned NBEATS = NCOLS / LANES;
  localparam int unsigned DEPTH  = 2 ** COL_W;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned DATA_W = NCOLS * COL_W;

  localparam logic [4:0] ASCON_SBOX [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic logic [COL_W-1:0] reset_entry(input int unsigned i);
    if (COL_W == 5) begin
      return COL_W'(ASCON_SBOX[i[4:0]]);
    end else begin
      return COL_W'(i);
    end
  endfunction

  state_e             state_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [DATA_W-1:0]  cols_q;
  logic [DATA_W-1:0]  res_q;
  logic [COL_W-1:0]   table_q  [DEPTH];
  logic [COL_W-1:0]   lane_val [LANES];

  // Lookups read the registered table, so a write accepted on the capture edge is already visible.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_val[l] = table_q[cols_q[((32'(beat_q) * LANES) + l) * COL_W +: COL_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      cols_q  <= '0;
      res_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= reset_entry(i);
      end
    end else begin
      if (cfg_we && (state_q == StIdle)) begin
        table_q[cfg_addr] <= cfg_data;
      end
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            cols_q  <= in_data;
            beat_q  <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            res_q[((32'(beat_q) * LANES) + l) * COL_W +: COL_W] <= lane_val[l];
          end
          if (32'(beat_q) == NBEATS - 1) begin
            state_q <= StDone;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign cfg_ready = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = res_q;

endmodule

// File: tb/tb_sbox_lane_engine.sv
// Directed bench for sbox_lane_engine at default parameters (5-bit columns, 4 lanes, 64 columns).
module tb_sbox_lane_engine;

  localparam int unsigned DW = 320;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [4:0]    cfg_addr;
  logic [4:0]    cfg_data;
  logic          cfg_ready;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  int n_checks = 0;
  int n_fails  = 0;
  int cnt;

  logic [4:0]    sbox [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };
  logic [DW-1:0] pat;
  logic [DW-1:0] pat_exp;
  logic [DW-1:0] held;

  sbox_lane_engine dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rep(input logic [4:0] v);
    return {64{v}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  // Accept one transaction and return the number of edges until out_valid rises.
  task automatic run_txn(input logic [DW-1:0] d, output int edges);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(edges);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      pat[k*5 +: 5]     = 5'(k % 32);
      pat_exp[k*5 +: 5] = sbox[k % 32];
    end

    // Reset state
    do_reset();
    chk("rst_in_ready", DW'(in_ready), DW'(1'b1));
    chk("rst_cfg_ready", DW'(cfg_ready), DW'(1'b1));
    chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
    chk("rst_out_data", out_data, '0);

    // All-zero transaction: latency 16 and S[0] = 0x04 everywhere
    run_txn('0, cnt);
    chk("zero_latency", DW'(cnt), DW'(16));
    chk("zero_data", out_data, rep(5'h04));
    chk("zero_in_ready_done", DW'(in_ready), DW'(1'b0));
    tick();
    chk("zero_in_ready_after", DW'(in_ready), DW'(1'b1));
    chk("zero_out_valid_after", DW'(out_valid), DW'(1'b0));

    // Column k = k mod 32
    run_txn(pat, cnt);
    chk("pat_latency", DW'(cnt), DW'(16));
    chk("pat_data", out_data, pat_exp);
    chk("pat_col1", DW'(out_data[5 +: 5]), DW'(5'h0B));
    chk("pat_col31", DW'(out_data[155 +: 5]), DW'(5'h17));
    chk("pat_col33", DW'(out_data[165 +: 5]), DW'(5'h0B));
    tick();

    // Table write in IDLE, then all-zero transaction
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 5'h1F;
    tick();
    cfg_we = 1'b0;
    run_txn('0, cnt);
    chk("cfgw_data", out_data, rep(5'h1F));
    tick();

    // Table write on the same edge as acceptance
    do_reset();
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 5'h1F;
    in_data = '0; in_valid = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    wait_done(cnt);
    chk("same_cycle_latency", DW'(cnt), DW'(16));
    chk("same_cycle_data", out_data, rep(5'h1F));
    tick();

    // Write attempt and new input during BUSY are ignored
    in_data = '0; in_valid = 1'b1;
    tick();
    in_data = pat;
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 5'h00;
    tick();
    chk("busy_cfg_ready", DW'(cfg_ready), DW'(1'b0));
    chk("busy_in_ready", DW'(in_ready), DW'(1'b0));
    tick(); tick(); tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    wait_done(cnt);
    chk("busy_done_seen", DW'(out_valid), DW'(1'b1));
    chk("busy_data", out_data, rep(5'h1F));
    tick();
    run_txn('0, cnt);
    chk("busy_later_data", out_data, rep(5'h1F));
    tick();

    // Output stall with out_ready low for 10 cycles
    do_reset();
    out_ready = 1'b0;
    run_txn(pat, cnt);
    chk("stall_latency", DW'(cnt), DW'(16));
    held = out_data;
    chk("stall_first_data", held, pat_exp);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_out_valid", DW'(out_valid), DW'(1'b1));
      chk("stall_out_data", out_data, held);
      chk("stall_in_ready", DW'(in_ready), DW'(1'b0));
    end
    out_ready = 1'b1;
    tick();
    chk("release_in_ready", DW'(in_ready), DW'(1'b1));
    chk("release_out_valid", DW'(out_valid), DW'(1'b0));

    // Reset at beat 7 discards the result and restores the default table
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 5'h00;
    tick();
    cfg_we = 1'b0;
    in_data = pat; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_busy", DW'(in_ready), DW'(1'b0));
    do_reset();
    chk("midrst_in_ready", DW'(in_ready), DW'(1'b1));
    chk("midrst_out_valid", DW'(out_valid), DW'(1'b0));
    chk("midrst_out_data", out_data, '0);
    run_txn('0, cnt);
    chk("midrst_table_default", out_data, rep(5'h04));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
